// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared sizing helpers and types for the async FIFO read side
package async_fifo_pkg;

  localparam int MAX_RD_LATENCY = 2;

  // One bit per outstanding memory read; bits above RD_LATENCY stay zero.
  typedef logic [MAX_RD_LATENCY-1:0] rd_tag_t;

  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// rtl/fifo_rd_obuf.sv - small circular output buffer with head data and fill level
module fifo_rd_obuf
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  // Explicit wrap compare: DEPTH is usually not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ptr_inc(tail);
      end
      if (rd_en) head <= ptr_inc(head);
      if (wr_en && !rd_en)      level <= level + 1'b1;
      else if (!wr_en && rd_en) level <= level - 1'b1;
    end
  end

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (!rst) assert (!(wr_en && !rd_en && level == $bits(level)'(DEPTH)));
  end

endmodule

// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - FWFT read stage for the async FIFO; FIFO_RD_STALL_CNT_EN adds stall_cnt
module fifo_rd_fwft
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int SOFT_RESET = 0
) (
  input  logic                                     rclk,
  input  logic                                     hw_rst,
  input  logic                                     soft_rst,
  input  logic                                     rdempty,
  output logic                                     rinc,
  input  logic [DATA_WIDTH-1:0]                    rdata,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [DATA_WIDTH-1:0]                    m_data,
  output logic [lvl_w(buf_depth(RD_LATENCY))-1:0]  buf_level
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [15:0]                              stall_cnt
`endif
);

  localparam int      BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int      LW        = lvl_w(BUF_DEPTH);
  localparam bit      SOFT_EN   = (SOFT_RESET == 1) || (SOFT_RESET == 3);
  localparam rd_tag_t TAG_MASK  = rd_tag_t'((1 << RD_LATENCY) - 1);

  logic          rst;
  rd_tag_t       tags;
  logic [LW-1:0] inflight;
  logic          wr_en;
  logic          pop;

  assign rst = hw_rst || (SOFT_EN && soft_rst);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAX_RD_LATENCY; i++) inflight = inflight + LW'(tags[i]);
  end

  // Credit counts words already buffered plus reads still in the memory pipe.
  assign rinc  = !rdempty && !rst && ((buf_level + inflight) < LW'(BUF_DEPTH));
  assign wr_en = tags[RD_LATENCY-1] && !rst;

  always_ff @(posedge rclk) begin
    if (rst) tags <= '0;
    else     tags <= ((tags << 1) | rd_tag_t'(rinc)) & TAG_MASK;
  end

  assign m_valid = (buf_level != '0);
  assign pop     = m_valid && m_ready;

  fifo_rd_obuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_obuf (
    .clk       (rclk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (rdata),
    .rd_en     (pop),
    .head_data (m_data),
    .level     (buf_level)
  );

`ifdef FIFO_RD_STALL_CNT_EN
  always_ff @(posedge rclk) begin
    if (rst) stall_cnt <= '0;
    else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb/tb_fifo_rd_fwft.sv - scoreboard bench for fifo_rd_fwft at RD_LATENCY 1 and 2
module tb_fifo_rd_fwft;

  logic       clk = 1'b0;
  logic       sel = 1'b0;
  logic       hw_rst = 1'b1;
  logic       soft_rst = 1'b0;
  logic       rdempty = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] pipe0 = 8'h00;
  logic [7:0] pipe1 = 8'h00;
  logic [7:0] rdata;

  logic       hw1, hw2, re1, re2;
  logic       rinc1, rinc2, mv1, mv2;
  logic [7:0] md1, md2;
  logic [1:0] lvl1;
  logic [2:0] lvl2;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall1, stall2;
`endif

  logic       rinc_a, mv_a;
  logic [7:0] md_a;
  logic [2:0] lvl_a;

  always #5 clk = ~clk;

  assign hw1   = hw_rst | sel;
  assign hw2   = hw_rst | ~sel;
  assign re1   = rdempty | sel;
  assign re2   = rdempty | ~sel;
  assign rdata = sel ? pipe1 : pipe0;

  assign rinc_a = sel ? rinc2 : rinc1;
  assign mv_a   = sel ? mv2 : mv1;
  assign md_a   = sel ? md2 : md1;
  assign lvl_a  = sel ? lvl2 : {1'b0, lvl1};

  fifo_rd_fwft #(.DATA_WIDTH(8), .RD_LATENCY(1), .SOFT_RESET(1)) u1 (
`ifdef FIFO_RD_STALL_CNT_EN
    .stall_cnt (stall1),
`endif
    .rclk (clk), .hw_rst (hw1), .soft_rst (soft_rst), .rdempty (re1), .rinc (rinc1),
    .rdata (rdata), .m_valid (mv1), .m_ready (m_ready), .m_data (md1), .buf_level (lvl1)
  );

  fifo_rd_fwft #(.DATA_WIDTH(8), .RD_LATENCY(2), .SOFT_RESET(0)) u2 (
`ifdef FIFO_RD_STALL_CNT_EN
    .stall_cnt (stall2),
`endif
    .rclk (clk), .hw_rst (hw2), .soft_rst (soft_rst), .rdempty (re2), .rinc (rinc2),
    .rdata (rdata), .m_valid (mv2), .m_ready (m_ready), .m_data (md2), .buf_level (lvl2)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pop = 0;
  int         viol  = 0;
  int         cyc   = 0;
  int         max_lvl = 0;
  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  logic       s_rinc, s_mv, s_pop;
  logic [7:0] s_data;
  logic [2:0] s_lvl;

  typedef struct {
    logic sel;
    int   nwords;
    int   exp_rinc;
    int   exp_lvl;
  } bp_vec_t;
  bp_vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One read-clock cycle: sample DUT mid-cycle, then play pointer block and memory after the edge.
  task automatic step();
    logic [7:0] w;
    @(negedge clk);
    s_rinc = rinc_a;
    s_mv   = mv_a;
    s_pop  = mv_a && m_ready;
    s_data = md_a;
    s_lvl  = lvl_a;
    if (int'(s_lvl) > max_lvl) max_lvl = int'(s_lvl);
    if (s_rinc && rdempty) viol++;
    @(posedge clk);
    #1;
    cyc++;
    pipe1 = pipe0;
    if (s_rinc && src.size() != 0) begin
      w = src.pop_front();
      exp_q.push_back(w);
      pipe0 = w;
    end else begin
      pipe0 = 8'($urandom);
    end
    rdempty = (src.size() == 0);
    if (s_pop) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_order: got %0h expected none", s_data);
      end else begin
        check("pop_order", 32'(s_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic do_reset();
    m_ready = 1'b0;
    hw_rst  = 1'b1;
    src.delete();
    rdempty = 1'b1;
    step();
    hw_rst = 1'b0;
    exp_q.delete();
    n_pop = 0;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + 8'(i));
    rdempty = (src.size() == 0);
  endtask

  initial begin
    int first_r, first_v, first_p, last_p, nr, k, nst;
    logic [7:0] base;
`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] prev;
`endif
    tbl[0] = '{1'b0, 8, 3, 3};
    tbl[1] = '{1'b0, 2, 2, 2};
    tbl[2] = '{1'b0, 1, 1, 1};
    tbl[3] = '{1'b0, 0, 0, 0};
    tbl[4] = '{1'b1, 8, 4, 4};
    tbl[5] = '{1'b1, 3, 3, 3};

    // Reset state with the FIFO claiming non-empty.
    sel = 1'b0; hw_rst = 1'b1; rdempty = 1'b0;
    step();
    check("rst_rinc", 32'(s_rinc), 0);
    check("rst_valid", 32'(mv_a), 0);
    check("rst_level", 32'(lvl_a), 0);
    check("rst_data", 32'(md_a), 0);
    hw_rst = 1'b0; rdempty = 1'b1;

    // Streaming, RD_LATENCY=1.
    do_reset();
    load(10, 8'h01);
    m_ready = 1'b1;
    first_r = -1; first_v = -1; first_p = -1; last_p = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rinc && first_r < 0) first_r = cyc - 1;
      if (s_mv && first_v < 0) first_v = cyc - 1;
      if (s_pop) begin
        if (first_p < 0) first_p = cyc - 1;
        last_p = cyc - 1;
      end
    end
    check("stream_latency", 32'(first_v - first_r), 2);
    check("stream_consecutive", 32'(last_p - first_p), 9);
    check("stream_count", 32'(n_pop), 10);

    // Backpressure / empty-boundary table.
    for (int v = 0; v < 6; v++) begin
      sel = tbl[v].sel;
      do_reset();
      base = 8'h40 + 8'(v * 16);
      load(tbl[v].nwords, base);
      nr = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (s_rinc) nr++;
      end
      check("bp_rinc", 32'(nr), 32'(tbl[v].exp_rinc));
      check("bp_level", 32'(lvl_a), 32'(tbl[v].exp_lvl));
      check("bp_valid", 32'(mv_a), 32'(tbl[v].exp_lvl != 0));
      if (tbl[v].exp_lvl != 0) check("bp_head", 32'(md_a), 32'(base));
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) step();
      check("bp_drained", 32'(n_pop), 32'(tbl[v].nwords));
      check("bp_empty_level", 32'(lvl_a), 0);
    end

    // RD_LATENCY=2 with random consumer.
    sel = 1'b1;
    do_reset();
    load(200, 8'h00);
    max_lvl = 0;
    k = 0;
    while (n_pop < 200 && k < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check("rand_count", 32'(n_pop), 200);
    check("rand_max_level_ok", 32'(max_lvl <= 4), 1);

    // hw_rst with two reads in flight and two words buffered.
    do_reset();
    load(8, 8'h80);
    k = 0;
    while (lvl_a != 3'd2 && k < 20) begin
      step();
      k++;
    end
    check("mid_pre_level", 32'(lvl_a), 2);
    hw_rst = 1'b1;
    step();
    hw_rst = 1'b0;
    src.delete(); rdempty = 1'b1; exp_q.delete();
    check("mid_rinc_in_rst", 32'(s_rinc), 0);
    check("mid_valid", 32'(mv_a), 0);
    check("mid_level", 32'(lvl_a), 0);
    for (int i = 0; i < 4; i++) step();
    check("mid_late_dropped_level", 32'(lvl_a), 0);
    check("mid_late_dropped_valid", 32'(mv_a), 0);

`ifdef FIFO_RD_STALL_CNT_EN
    sel = 1'b0;
    do_reset();
    load(1, 8'hA5);
    nst = 0; k = 0;
    while (nst < 5 && k < 20) begin
      step();
      if (s_mv) nst++;
      k++;
    end
    check("stall_count5", 32'(stall1), 5);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    exp_q.delete();
    check("stall_soft_clear", 32'(stall1), 0);
    check("stall_soft_valid", 32'(mv_a), 0);

    sel = 1'b1;
    do_reset();
    load(1, 8'h5A);
    for (int i = 0; i < 6; i++) step();
    prev = stall2;
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    check("stall_soft_ignored", 32'(stall2), 32'(prev + 16'd1));
    check("stall_soft_ignored_valid", 32'(mv_a), 1);
`endif

    check("no_rinc_while_empty", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
